traffic_phase_scheduler: RTL and testbench



---
 rtl/traffic_pkg.sv | 21 ++
 rtl/traffic_phase_scheduler_rr_pick.sv | 28 ++
 rtl/traffic_phase_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic phase scheduler.
// Lamp vectors are bit i = approach i.
package traffic_pkg;

  localparam int NUM_APPROACH = 4;

  typedef logic [1:0] appr_t;

  typedef enum logic [1:0] {
    ALL_RED = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2
  } state_t;

  localparam logic [3:0] ALL_RED_LAMPS = 4'b1111;

  function automatic logic [3:0] onehot(appr_t a);
    return 4'b0001 << a;
  endfunction

endpackage

// File: rtl/traffic_phase_scheduler_rr_pick.sv
// Round-robin pick: first pending approach after cur,
// wrapping back to cur itself as the last candidate.
module rr_pick
  import traffic_pkg::*;
(
  input  logic [3:0] pending,
  input  appr_t      cur,
  output appr_t      grant,
  output logic       valid
);

  appr_t idx;

  // Scan cur+4 down to cur+1 so the nearest successor wins last.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = NUM_APPROACH; k >= 1; k--) begin
      idx = cur + 2'(k);
      if (pending[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated 4-approach phase scheduler (ALL_RED/GREEN/YELLOW).
// Optional emergency preemption under macro TRAFFIC_PREEMPT_EN.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int G_MIN = 5,
  parameter int G_MAX = 15,
  parameter int Y_T   = 3,
  parameter int RED_T = 1,
  parameter int TW    = 4
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] req,
`ifdef TRAFFIC_PREEMPT_EN
  input  logic [3:0] preempt,
  output logic       preempt_active,
`endif
  output logic [3:0] R,
  output logic [3:0] Y,
  output logic [3:0] G,
  output logic [1:0] cur,
  output logic [3:0] phase_cnt
);

  localparam logic [TW-1:0] RED_L  = TW'(RED_T - 1);
  localparam logic [TW-1:0] GMIN_L = TW'(G_MIN - 1);
  localparam logic [TW-1:0] GMAX_L = TW'(G_MAX - 1);
  localparam logic [TW-1:0] Y_L    = TW'(Y_T - 1);
  localparam logic [TW-1:0] T_SAT  = '1;

  state_t        st_q, st_n;
  appr_t         cur_n;
  logic [TW-1:0] tmr_q, tmr_n;
  logic [3:0]    pend_q, pend_n, pend_eff;
  logic [3:0]    cur_oh, gmask;
  appr_t         pk_idx, gnt_i;
  logic          pk_vld, gnt_v;
  logic          others, go_y;
  logic [3:0]    r_n, y_n, g_n, cnt_n;
  logic [TW+3:0] t_ext;

  assign cur_oh   = onehot(cur);
  assign gmask    = (st_q == GREEN) ? cur_oh : 4'b0000;
  assign pend_eff = pend_q | (req & ~gmask);
  assign others   = |(pend_eff & ~cur_oh);

  rr_pick u_pick (
    .pending (pend_eff),
    .cur     (cur),
    .grant   (pk_idx),
    .valid   (pk_vld)
  );

`ifdef TRAFFIC_PREEMPT_EN
  logic  pre_any;
  appr_t pre_tgt;

  assign pre_any = |preempt;

  // Lowest-index emergency request is the target.
  always_comb begin
    pre_tgt = '0;
    for (int i = NUM_APPROACH - 1; i >= 0; i--) begin
      if (preempt[i]) pre_tgt = 2'(i);
    end
  end
`endif

  // Next state, owner, timer and pending requests.
  always_comb begin
    st_n   = st_q;
    cur_n  = cur;
    tmr_n  = tmr_q;
    pend_n = pend_eff;
    go_y   = 1'b0;
`ifdef TRAFFIC_PREEMPT_EN
    gnt_v  = pre_any | pk_vld;
    gnt_i  = pre_any ? pre_tgt : pk_idx;
`else
    gnt_v  = pk_vld;
    gnt_i  = pk_idx;
`endif
    if (tick) begin
      unique case (st_q)
        ALL_RED: begin
          if (tmr_q >= RED_L) begin
            if (gnt_v) begin
              st_n   = GREEN;
              cur_n  = gnt_i;
              tmr_n  = '0;
              pend_n = pend_eff & ~onehot(gnt_i);
            end
          end else begin
            tmr_n = tmr_q + 1'b1;
          end
        end
        GREEN: begin
          go_y = others &&
                 ((tmr_q >= GMAX_L) ||
                  ((tmr_q >= GMIN_L) && !req[cur]));
`ifdef TRAFFIC_PREEMPT_EN
          if (pre_any) go_y = (pre_tgt != cur);
`endif
          if (go_y) begin
            st_n  = YELLOW;
            tmr_n = '0;
          end else if (tmr_q != T_SAT) begin
            tmr_n = tmr_q + 1'b1;
          end
        end
        YELLOW: begin
          if (tmr_q >= Y_L) begin
            st_n  = ALL_RED;
            tmr_n = '0;
          end else begin
            tmr_n = tmr_q + 1'b1;
          end
        end
        default: begin
          st_n  = ALL_RED;
          tmr_n = '0;
        end
      endcase
    end
  end

  // Lamp and counter values for the next cycle.
  always_comb begin
    r_n   = ALL_RED_LAMPS;
    y_n   = 4'b0000;
    g_n   = 4'b0000;
    t_ext = {4'b0000, tmr_n};
    cnt_n = (t_ext > (TW + 4)'(15)) ? 4'hf : t_ext[3:0];
    unique case (st_n)
      GREEN: begin
        g_n = onehot(cur_n);
        r_n = ~onehot(cur_n);
      end
      YELLOW: begin
        y_n = onehot(cur_n);
        r_n = ~onehot(cur_n);
      end
      default: begin
        r_n = ALL_RED_LAMPS;
      end
    endcase
  end

  // State register with registered lamp outputs.
  always_ff @(posedge clkin) begin
    if (rst) begin
      st_q      <= ALL_RED;
      cur       <= 2'd3;
      tmr_q     <= '0;
      pend_q    <= 4'b0000;
      R         <= ALL_RED_LAMPS;
      Y         <= 4'b0000;
      G         <= 4'b0000;
      phase_cnt <= 4'b0000;
    end else begin
      st_q      <= st_n;
      cur       <= cur_n;
      tmr_q     <= tmr_n;
      pend_q    <= pend_n;
      R         <= r_n;
      Y         <= y_n;
      G         <= g_n;
      phase_cnt <= cnt_n;
    end
  end

`ifdef TRAFFIC_PREEMPT_EN
  // Registered emergency indicator.
  always_ff @(posedge clkin) begin
    if (rst) preempt_active <= 1'b0;
    else     preempt_active <= pre_any;
  end
`endif

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: directed literal checks
// plus randomized traffic against a behavioural model.
module tb_traffic_phase_scheduler;

  localparam int G_MIN = 5;
  localparam int G_MAX = 15;
  localparam int Y_T   = 3;
  localparam int RED_T = 1;

  logic       clkin = 1'b0;
  logic       rst   = 1'b1;
  logic       tick  = 1'b0;
  logic [3:0] req   = 4'b0000;
  logic [3:0] R, Y, G, phase_cnt;
  logic [1:0] cur;
`ifdef TRAFFIC_PREEMPT_EN
  logic [3:0] preempt = 4'b0000;
  logic       preempt_active;
`endif

  int checks   = 0;
  int failures = 0;

  traffic_phase_scheduler dut (
    .clkin     (clkin),
    .rst       (rst),
    .tick      (tick),
    .req       (req),
`ifdef TRAFFIC_PREEMPT_EN
    .preempt        (preempt),
    .preempt_active (preempt_active),
`endif
    .R         (R),
    .Y         (Y),
    .G         (G),
    .cur       (cur),
    .phase_cnt (phase_cnt)
  );

  always #5 clkin = ~clkin;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0=all-red 1=green 2=yellow.
  int m_ph   = 0;
  int m_cur  = 3;
  int m_t    = 0;
  bit m_pend [4];

  always @(posedge clkin) begin
    int  a;
    bit  found, oth;
    if (rst) begin
      m_ph = 0; m_cur = 3; m_t = 0;
      for (int i = 0; i < 4; i++) m_pend[i] = 0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (req[i] && !(m_ph == 1 && m_cur == i)) m_pend[i] = 1;
      if (tick) begin
        if (m_ph == 0) begin
          if (m_t + 1 >= RED_T) begin
            found = 0; a = 0;
            for (int k = 1; k <= 4; k++)
              if (!found && m_pend[(m_cur + k) % 4]) begin
                found = 1; a = (m_cur + k) % 4;
              end
            if (found) begin
              m_ph = 1; m_cur = a; m_t = 0; m_pend[a] = 0;
            end
          end else m_t++;
        end else if (m_ph == 1) begin
          oth = 0;
          for (int j = 0; j < 4; j++)
            if (j != m_cur && m_pend[j]) oth = 1;
          if (oth && (m_t + 1 >= G_MAX ||
                      (m_t + 1 >= G_MIN && !req[m_cur]))) begin
            m_ph = 2; m_t = 0;
          end else if (m_t < 15) m_t++;
        end else begin
          if (m_t + 1 >= Y_T) begin
            m_ph = 0; m_t = 0;
          end else m_t++;
        end
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clkin) begin
    logic [3:0] oh, eg, ey, er;
    oh = 4'b0001 << m_cur;
    eg = (m_ph == 1) ? oh : 4'b0000;
    ey = (m_ph == 2) ? oh : 4'b0000;
    er = (m_ph == 0) ? 4'b1111 : ~oh;
    chk("G", 32'(G), 32'(eg));
    chk("Y", 32'(Y), 32'(ey));
    chk("R", 32'(R), 32'(er));
    chk("cur", 32'(cur), 32'(m_cur));
    chk("phase_cnt", 32'(phase_cnt),
        32'((m_t > 15) ? 15 : m_t));
    chk("one_lamp",
        32'(((R | Y | G) == 4'hf) &&
            (((R & Y) | (R & G) | (Y & G)) == 4'h0)), 32'd1);
`ifdef TRAFFIC_PREEMPT_EN
    chk("preempt_active", 32'(preempt_active), 32'd0);
`endif
  end

  task automatic cyc(input logic r, input logic t,
                     input logic [3:0] q);
    rst = r; tick = t; req = q;
    @(posedge clkin);
    #1;
  endtask

  int hold = 0;
  logic [3:0] rq = 4'b0000;

  initial begin
    // Reset, then idle ticks: rest in all-red.
    cyc(1, 0, 4'b0000);
    chk("rst_R", 32'(R), 32'hf);
    chk("rst_cur", 32'(cur), 32'd3);
    repeat (20) cyc(0, 1, 4'b0000);
    chk("idle_R", 32'(R), 32'hf);
    chk("idle_G", 32'(G), 32'h0);
    chk("idle_cnt", 32'(phase_cnt), 32'h0);

    // Single request: green rests without yellow.
    cyc(1, 0, 4'b0000);
    cyc(0, 1, 4'b0001);
    chk("solo_G", 32'(G), 32'h1);
    repeat (30) cyc(0, 1, 4'b0001);
    chk("solo_rest_G", 32'(G), 32'h1);
    chk("solo_rest_cnt", 32'(phase_cnt), 32'd15);

    // Two requests: max green, yellow, all-red, then 2.
    cyc(1, 0, 4'b0000);
    cyc(0, 1, 4'b0101);
    chk("gmax_G0", 32'(G), 32'h1);
    repeat (14) cyc(0, 1, 4'b0101);
    chk("gmax_G14", 32'(G), 32'h1);
    chk("gmax_cnt14", 32'(phase_cnt), 32'd14);
    cyc(0, 1, 4'b0101);
    chk("gmax_Y", 32'(Y), 32'h1);
    cyc(0, 1, 4'b0101);
    cyc(0, 1, 4'b0101);
    chk("gmax_Y2", 32'(Y), 32'h1);
    cyc(0, 1, 4'b0101);
    chk("gmax_red", 32'(R), 32'hf);
    cyc(0, 1, 4'b0101);
    chk("gmax_G2", 32'(G), 32'h4);
    repeat (19) cyc(0, 1, 4'b0101);
    chk("gmax_back0", 32'(G), 32'h1);

    // Request drops early: yellow waits for minimum green.
    cyc(1, 0, 4'b0000);
    cyc(0, 1, 4'b0001);
    repeat (4) cyc(0, 1, 4'b0010);
    chk("gmin_hold", 32'(G), 32'h1);
    cyc(0, 1, 4'b0010);
    chk("gmin_Y", 32'(Y), 32'h1);
    cyc(0, 1, 4'b0010);
    // Reset mid-yellow.
    cyc(1, 1, 4'b0010);
    chk("midrst_R", 32'(R), 32'hf);
    chk("midrst_cur", 32'(cur), 32'd3);
    chk("midrst_cnt", 32'(phase_cnt), 32'd0);

    // Wrap-around pick from cur=3 with pending 1001.
    cyc(0, 1, 4'b1001);
    chk("wrap_G", 32'(G), 32'h1);
    chk("wrap_cur", 32'(cur), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      if (hold == 0) begin
        rq   = ($urandom_range(0, 4) == 0) ? 4'b0000
                                           : 4'($urandom_range(0, 15));
        hold = $urandom_range(1, 30);
      end
      hold--;
      cyc(($urandom_range(0, 599) == 0), ($urandom_range(0, 3) != 0), rq);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
